cordic_sched: RTL
=================

# cordic_sched

Round-robin scheduler that shares one 16-bit hyperbolic CORDIC core (`cordic_2taylor`) among N requesters.
- Accepts angle/x/y jobs over valid/ready and drives the core's operand inputs for the fixed core latency.
- Captures `Xout`/`Yout` (cosh/sinh) and returns them with the requester ID over a valid/ready response port.
- Sits between the core and the client blocks that need cosh/sinh.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `LATENCY`, 8, core cycles from stable operands to valid outputs (≥1)
- `ANG_LIMIT`, 16'sd18318, max |angle| in Q2.14 (≈1.118 rad); used only when range check is compiled in

Ports (reset is synchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous active-low reset (0 = reset)
- `req_valid`  in  N  per-requester job valid
- `req_ready`  out  N  per-requester accept; one-hot or zero
- `req_ang`  in  N*16  signed Q2.14 angle; requester i at [16i+15:16i]
- `req_x`  in  N*16  signed Q2.14 x; 0x4000 = 1.0
- `req_y`  in  N*16  signed Q2.14 y
- `core_ang`  out  16  registered angle to core `ang`
- `core_xin`  out  16  registered x to core `xin`
- `core_yin`  out  16  registered y to core `yin`
- `core_xout`  in  16  core `Xout` (cosh)
- `core_yout`  in  16  core `Yout` (sinh)
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  $clog2(N)  requester index of the response
- `rsp_x`  out  16  captured cosh
- `rsp_y`  out  16  captured sinh
- `rsp_err`  out  1  job rejected (range check only; else tied 0)
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, RESP.
- **IDLE**
  - Round-robin pick among asserted `req_valid`. Search starts at `last+1` mod N.
  - `req_ready[g]` = 1 combinationally for the winner g only.
  - Handshake (`req_valid[g] & req_ready[g]`) at an edge:
    - register g's operands into `core_*`;
    - set `rsp_id` ← g and `last` ← g;
    - load `cnt` ← LATENCY-1;
    - go to RUN.
- **RUN**
  - `req_ready` = 0 and `core_*` are held constant.
  - Each edge: if `cnt`==0, capture `core_xout`/`core_yout` into `rsp_x`/`rsp_y` and go to RESP; otherwise decrement `cnt`.
- **RESP**
  - `rsp_valid` = 1; `rsp_*` are stable until the handshake.
  - `rsp_valid & rsp_ready` at an edge → IDLE.
  - `rsp_ready` held low stalls indefinitely. No new job is accepted meanwhile.
- Requester side:
  - `req_valid` may drop without a handshake; there is no penalty.
  - Operands are sampled only at the accept edge.
- Arithmetic: no modification of core data. Outputs are a pass-through of the 16-bit signed values.

## Timing
- Reset values: state=IDLE, `req_ready`=0 (driven combinationally, but 0 when all valid are low), `core_ang`/`core_xin`/`core_yin`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_x`=`rsp_y`=0, `rsp_err`=0, `busy`=0, `cnt`=0, `last`=N-1 (requester 0 has first priority).
- Latency:
  - Accept at edge E0; core operands valid from E0.
  - Capture at edge E0+LATENCY; `rsp_valid` is high after that edge.
- Minimum per-job period: LATENCY+2 cycles (accept edge, LATENCY, response edge). IDLE may re-accept on the edge after the response handshake.
- Simultaneous requests: exactly one is granted per IDLE cycle. A requester held valid is served within N jobs.
- Reset asserted mid-RUN/RESP: the in-flight job is discarded, no response is issued, and all state returns to reset values on that edge.
- `cnt` width is $clog2(LATENCY)+1; it never wraps.

## Configuration
- Macro: `CORDIC_SCHED_RANGE_CHECK_EN`.
- **Defined:** at accept, if `req_ang` > ANG_LIMIT or < -ANG_LIMIT:
  - core operands are not updated;
  - the FSM goes directly to RESP with `rsp_err`=1, `rsp_x`=`rsp_y`=0 and `rsp_id`=g;
  - the response is visible the cycle after accept.
  - In-range jobs behave as normal with `rsp_err`=0.
- **Undefined:** no check; `rsp_err` is constant 0 and every job uses the core.

## Test plan
- **Single job.** Requester 0 sends ang=0x1DAC, x=0x4000, y=0 with LATENCY=8 and a core model → `rsp_valid` rises 8 edges after accept; `rsp_id`=0; `rsp_x`/`rsp_y` equal model cosh/sinh; `core_*` are held for 8 cycles.
- **Fairness.** All 4 requesters valid continuously → grant order 0,1,2,3,0; each `req_ready` is one-hot and only in IDLE.
- **Response stall.** `rsp_ready`=0 for 20 cycles in RESP → `rsp_x`/`rsp_y`/`rsp_id` stable; `req_ready`=0 throughout; IDLE on the edge `rsp_ready`=1.
- **Reset mid-RUN.** `reset`=0 at cycle 4 of RUN → next edge: `busy`=0, `core_*`=0, no `rsp_valid` pulse; the following job from requester 2 is served normally.
- **Range check** (`CORDIC_SCHED_RANGE_CHECK_EN` defined). ang=0x5000 → `rsp_err`=1 and `rsp_x`=`rsp_y`=0 one cycle after accept, `core_ang` unchanged; ang=0x478E → normal path, `rsp_err`=0.
- **Withdrawn request.** Requester 1 pulses `req_valid` during RUN only → never granted; `last` unchanged.

Source files
------------

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - round-robin scheduler sharing one hyperbolic CORDIC core among N requesters
// Optional range check on the job angle: define CORDIC_SCHED_RANGE_CHECK_EN.
module cordic_sched #(
  parameter int                 N         = 4,
  parameter int                 LATENCY   = 8,
  parameter logic signed [15:0] ANG_LIMIT = 16'sd18318
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N-1:0]                      req_valid,
  output logic [N-1:0]                      req_ready,
  input  logic [N*16-1:0]                   req_ang,
  input  logic [N*16-1:0]                   req_x,
  input  logic [N*16-1:0]                   req_y,
  output logic [15:0]                       core_ang,
  output logic [15:0]                       core_xin,
  output logic [15:0]                       core_yin,
  input  logic [15:0]                       core_xout,
  input  logic [15:0]                       core_yout,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] rsp_id,
  output logic [15:0]                       rsp_x,
  output logic [15:0]                       rsp_y,
  output logic                              rsp_err,
  output logic                              busy
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_last;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_core_ang;
  logic [15:0]      r_core_xin;
  logic [15:0]      r_core_yin;
  logic [IDW-1:0]   r_rsp_id;
  logic [15:0]      r_rsp_x;
  logic [15:0]      r_rsp_y;

  logic             w_any;
  logic [IDW-1:0]   w_gnt;
  logic [15:0]      w_ang;
  logic [15:0]      w_x;
  logic [15:0]      w_y;
  logic             w_accept;
  logic             w_oor;

  // Round-robin search from last+1; walking downward leaves the nearest candidate as winner.
  always_comb begin
    logic [IDW-1:0] idx;
    w_any = 1'b0;
    w_gnt = '0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDW'((int'(r_last) + k) % N);
      if (req_valid[idx]) begin
        w_any = 1'b1;
        w_gnt = idx;
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    w_ang = '0;
    w_x   = '0;
    w_y   = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gnt == IDW'(k)) begin
        w_ang = req_ang[16*k +: 16];
        w_x   = req_x[16*k +: 16];
        w_y   = req_y[16*k +: 16];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_any;

`ifdef CORDIC_SCHED_RANGE_CHECK_EN
  assign w_oor = ($signed(w_ang) > ANG_LIMIT) || ($signed(w_ang) < -ANG_LIMIT);
`else
  assign w_oor = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; rejected jobs skip the core and answer at once.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_oor ? S_RESP : S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; grant is only offered while idle.
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_any) req_ready[w_gnt] = 1'b1;
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

  // Operand hold, latency countdown and result capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last     <= IDW'(N - 1);
      r_cnt      <= '0;
      r_core_ang <= '0;
      r_core_xin <= '0;
      r_core_yin <= '0;
      r_rsp_id   <= '0;
      r_rsp_x    <= '0;
      r_rsp_y    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rsp_id <= w_gnt;
            r_last   <= w_gnt;
            if (w_oor) begin
              r_rsp_x <= '0;
              r_rsp_y <= '0;
            end else begin
              r_core_ang <= w_ang;
              r_core_xin <= w_x;
              r_core_yin <= w_y;
              r_cnt      <= CW'(LATENCY - 1);
            end
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_rsp_x <= core_xout;
            r_rsp_y <= core_yout;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CORDIC_SCHED_RANGE_CHECK_EN
  logic r_rsp_err;

  // Error flag follows the range decision of each accepted job.
  always_ff @(posedge clk) begin
    if (!reset)        r_rsp_err <= 1'b0;
    else if (w_accept) r_rsp_err <= w_oor;
  end

  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign core_ang = r_core_ang;
  assign core_xin = r_core_xin;
  assign core_yin = r_core_yin;
  assign rsp_id   = r_rsp_id;
  assign rsp_x    = r_rsp_x;
  assign rsp_y    = r_rsp_y;

endmodule
